// File: rtl/pipelined_segmented_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipelined_segmented_adder
// Purpose  : Pipelined widening adder. A WA-bit unsigned operand A is added
//            to a WB-bit operand B that is zero- or sign-extended to WA+1
//            bits, giving a WA+1-bit sum (mod 2^(WA+1)). The carry chain is
//            cut into SEG-bit segments with one register stage per segment.
//            A valid/ready handshake with a single global stall provides
//            backpressure.
// Ports    : clk          rising-edge clock
//            rst          asynchronous active-high reset
//            in_valid     input transaction present
//            in_ready     block accepts input this cycle
//            in_a[WA-1:0] operand A (unsigned)
//            in_b[WB-1:0] operand B
//            in_b_signed  1: sign-extend B, 0: zero-extend B
//            out_valid    out_sum holds a result
//            out_ready    downstream accepts the result
//            out_sum[WA:0] result
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_segmented_adder #(
  parameter int WA  = 47,
  parameter int WB  = 4,
  parameter int SEG = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] in_a,
  input  logic [WB-1:0] in_b,
  input  logic          in_b_signed,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WA:0]   out_sum
);

  // ceil((WA+1)/SEG): number of stages and latency in cycles
  localparam int NSEG = (WA + SEG) / SEG;

  logic                 w_stall;
  logic [WA:0]          w_ext_a;
  logic [WA:0]          w_ext_b;

  // Per-stage state. r_x carries finished sum bits for the segments already
  // processed and the still-unused A bits above them, so the low result
  // bits are deskewed and the high operand bits skewed in one register.
  // r_y carries the extended B operand forward.
  logic [NSEG-1:0]         r_v;
  logic [NSEG-1:0]         r_c;
  logic [NSEG-1:0][WA:0]   r_x;
  logic [NSEG-1:0][WA:0]   r_y;
  logic [NSEG-1:0]         w_v_nxt;
  logic [NSEG-1:0]         w_c_nxt;
  logic [NSEG-1:0][WA:0]   w_x_nxt;
  logic [NSEG-1:0][WA:0]   w_y_nxt;

  assign w_stall  = r_v[NSEG-1] & ~out_ready;
  assign in_ready = ~w_stall;

  assign w_ext_a = {1'b0, in_a};
  assign w_ext_b = {{(WA + 1 - WB){in_b_signed & in_b[WB-1]}}, in_b};

  generate
    for (genvar k = 0; k < NSEG; k++) begin : g_stage
      localparam int LO = k * SEG;
      // The top segment is truncated at bit WA
      localparam int SW = ((WA + 1 - LO) < SEG) ? (WA + 1 - LO) : SEG;

      logic [WA:0] w_x_in;
      logic [WA:0] w_y_in;
      logic        w_c_in;
      logic        w_v_in;
      logic [SW:0] w_seg;
      logic [WA:0] w_x_new;

      if (k == 0) begin : g_first
        // Stage 0 only updates when not stalled, so in_valid equals acceptance
        assign w_x_in = w_ext_a;
        assign w_y_in = w_ext_b;
        assign w_c_in = 1'b0;
        assign w_v_in = in_valid;
      end else begin : g_next
        assign w_x_in = r_x[k-1];
        assign w_y_in = r_y[k-1];
        assign w_c_in = r_c[k-1];
        assign w_v_in = r_v[k-1];
      end

      assign w_seg = {1'b0, w_x_in[LO +: SW]} + {1'b0, w_y_in[LO +: SW]}
                   + {{SW{1'b0}}, w_c_in};

      always_comb begin
        w_x_new            = w_x_in;
        w_x_new[LO +: SW]  = w_seg[SW-1:0];
      end

      assign w_x_nxt[k] = w_x_new;
      assign w_y_nxt[k] = w_y_in;
      assign w_c_nxt[k] = w_seg[SW];
      assign w_v_nxt[k] = w_v_in;
    end
  endgenerate

  // One global enable: every stage advances together or holds together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
      r_c <= '0;
      r_x <= '0;
      r_y <= '0;
    end else if (!w_stall) begin
      r_v <= w_v_nxt;
      r_c <= w_c_nxt;
      r_x <= w_x_nxt;
      r_y <= w_y_nxt;
    end
  end

  assign out_valid = r_v[NSEG-1];
  assign out_sum   = r_x[NSEG-1];

  // The final carry-out wraps away and the last B copy has no consumer
  logic w_unused;
  assign w_unused = ^{r_c[NSEG-1], r_y[NSEG-1]};

endmodule
`default_nettype wire

// File: doc/pipelined_segmented_adder.md
Name: pipelined_segmented_adder

Overview:
- Parametrised, pipelined successor to the fixed 47+4 widening adder used in the multiplier/normalisation datapath.
- Adds a WA-bit operand A to a WB-bit operand B, extended to WA+1 bits, and produces a WA+1-bit sum.
- The carry chain is split into SEG-bit segments with one register stage per segment, so wide sums meet timing.
- Carries a valid/ready handshake with backpressure and a per-transaction signed/unsigned mode for B.

Parameters:
- WA, 47, width of operand A; WA >= 2.
- WB, 4, width of operand B; 1 <= WB <= WA.
- SEG, 16, carry-segment width in bits; 1 <= SEG <= WA+1.
- Derived: NSEG = ceil((WA+1)/SEG), the number of pipeline stages and the latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block accepts input this cycle.
- in_a  input  WA  operand A, always treated as unsigned.
- in_b  input  WB  operand B.
- in_b_signed  input  1  1: sign-extend B; 0: zero-extend B.
- out_valid  output  1  out_sum holds a result.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WA+1  result.

Behaviour:
- Arithmetic:
  - ext_b = in_b zero- or sign-extended to WA+1 bits; A is zero-extended to WA+1 bits.
  - out_sum = (A + ext_b) mod 2^(WA+1).
  - With in_b_signed=0 this equals the old fixed adder (bit WA is the carry-out).
- Segmentation:
  - Bits [k*SEG +: SEG] are summed in stage k, k = 0..NSEG-1; the last segment is truncated at bit WA.
  - Stage k uses the registered carry-out of stage k-1; stage 0 carry-in is 0.
  - Operand bits of segments > k are delayed (skewed) in registers until their stage.
  - Completed low segments are delayed (deskewed) so all WA+1 bits emerge together.
- Latency: a transaction accepted at edge t appears at out_valid/out_sum after edge t+NSEG-1, i.e. NSEG cycles, when there are no stalls. Throughput is one per cycle.
- Handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - When stall=1, every pipeline register (data and valid) holds.
  - When stall=0, all stages advance. A stage whose predecessor is empty receives valid=0 (bubble); its data register may hold or update, and is don't-care when invalid.
  - out_sum holds stable while out_valid=1 and out_ready=0.
  - Bubbles are not collapsed; a global stall is sufficient.
- Reset:
  - While rst=1, all valid bits = 0, out_valid = 0, out_sum = 0, and in_ready = 1 (stall is 0).
  - Asserting rst mid-operation discards all in-flight transactions immediately, asynchronously. No result of a pre-reset transaction ever appears after reset.
  - The first acceptance is possible on the first rising edge with rst=0.
- Boundaries:
  - in_valid while stalled is ignored: not accepted, and the source must hold its data.
  - Simultaneous out-transfer and in-transfer in the same cycle is legal; the pipeline advances.
  - Full carry propagation across all segments (e.g. all ones + 1) must be exact.
  - Overflow beyond WA+1 bits wraps, which can occur only in signed mode with a negative B.
  - NSEG=1 degenerates to a single registered adder with latency 1.

Test Plan:
- Defaults (WA=47, WB=4, SEG=16, NSEG=3), out_ready=1: A=0x7FFF_FFFF_FFFF, B=0x1, unsigned -> out_sum=0x8000_0000_0000, out_valid exactly 3 cycles after acceptance.
- Cross-segment carry: A=0x0000_FFFF_FFFF, B=0x1, unsigned -> 0x0001_0000_0000. Also A=0x0000_0000_FFFF, B=0x1 -> 0x0000_0001_0000.
- Signed B:
  - A=5, B=0xF, signed -> 0x0000_0000_0004.
  - A=0, B=0xF, signed -> 0xFFFF_FFFF_FFFF.
  - A=0, B=0xF, unsigned -> 0x0000_0000_000F.
- Backpressure: stream 6 back-to-back transactions with out_ready held low for cycles 4-7 -> in_ready=0 during the stall, out_sum stable, and all 6 results delivered in order with none lost or duplicated.
- Reset mid-flight: accept 2 transactions, then assert rst for 1 cycle one cycle later -> out_valid stays 0, neither result ever appears, and a transaction accepted after reset returns correctly after 3 cycles.
- Parameter sweep: SEG in {1, 7, 48} and WA=8/WB=8 with random operands in both modes -> matches the reference model with latency NSEG.
